// File: rtl/celda_inicial_der_izq.sv
// Bit-0 cell of the right-to-left magnitude comparator: produces the initial
// "A > B" state bit from A0/B0, optionally registered for per-cell pipelining.
module celda_inicial_der_izq #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A0,
  input  logic B0,
  output logic Pinit,
  output logic out_valid
);

  logic p_next;

  // No incoming state at bit 0: only A0=1, B0=0 makes A greater.
  assign p_next = A0 & ~B0;

  if (REG_OUT != 0) begin : g_reg
    logic pinit_q;
    logic valid_q;

    // Pinit holds its last value on idle cycles, so A0/B0 are never sampled unless valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        pinit_q <= '0;
        valid_q <= '0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          pinit_q <= p_next;
        end
      end
    end

    assign Pinit     = pinit_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign Pinit          = p_next;
    assign out_valid      = in_valid;
  end

endmodule

// File: tb/tb_celda_inicial_der_izq.sv
// Directed bench for celda_inicial_der_izq: registered instance plus a
// combinational instance sharing the same stimulus.
module tb_celda_inicial_der_izq;

  logic clk;
  logic rst;
  logic in_valid;
  logic A0;
  logic B0;
  logic pinit_r;
  logic out_valid_r;
  logic pinit_c;
  logic out_valid_c;

  int unsigned n_checks;
  int unsigned n_errors;

  celda_inicial_der_izq #(.REG_OUT(1)) dut_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A0       (A0),
    .B0       (B0),
    .Pinit    (pinit_r),
    .out_valid(out_valid_r)
  );

  celda_inicial_der_izq #(.REG_OUT(0)) dut_comb (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A0       (A0),
    .B0       (B0),
    .Pinit    (pinit_c),
    .out_valid(out_valid_c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic a, input logic b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A0       = a;
    B0       = b;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Expected Pinit for pairs 00,01,10,11 (A0 is the upper bit of the index)
  logic [3:0] exp_p;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_p    = 4'b0100;
    rst      = 1'b1;
    in_valid = 1'b1;
    A0       = 1'b1;
    B0       = 1'b0;

    // 1. Reset held two cycles with a valid 10 pair present
    for (int i = 0; i < 2; i++) begin
      after_edge();
      check("rst_pinit", pinit_r, 1'b0);
      check("rst_valid", out_valid_r, 1'b0);
    end

    // 2/5. Sweep 00..11, registered one cycle later, combinational immediately
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pr;
      pr = 2'(i);
      drive(1'b0, 1'b1, pr[1], pr[0]);
      #1;
      check($sformatf("comb_pinit_%0d", i), pinit_c, exp_p[i]);
      check($sformatf("comb_valid_%0d", i), out_valid_c, 1'b1);
      after_edge();
      check($sformatf("sweep_pinit_%0d", i), pinit_r, exp_p[i]);
      check($sformatf("sweep_valid_%0d", i), out_valid_r, 1'b1);
    end

    // 3. Valid 10 then idle 01: Pinit holds 1, out_valid drops
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("hold_set_pinit", pinit_r, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("comb_idle_valid", out_valid_c, 1'b0);
    check("comb_idle_pinit", pinit_c, 1'b0);
    after_edge();
    check("hold_pinit", pinit_r, 1'b1);
    check("hold_valid", out_valid_r, 1'b0);

    // 4. Stream 10,10(reset),11
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("mid_p0_pinit", pinit_r, 1'b1);
    check("mid_p0_valid", out_valid_r, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("mid_rst_pinit", pinit_r, 1'b0);
    check("mid_rst_valid", out_valid_r, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    after_edge();
    check("mid_p2_pinit", pinit_r, 1'b0);
    check("mid_p2_valid", out_valid_r, 1'b1);

    // First pair after reset reaches the output one cycle later
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    check("post_rst_pinit", pinit_r, 1'b1);

    // 6. Unknown A0/B0 while idle must not disturb the held value
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'bx, 1'bx);
      after_edge();
      check($sformatf("x_pinit_%0d", i), pinit_r, 1'b1);
      check($sformatf("x_known_%0d", i), $isunknown(pinit_r), 1'b0);
      check($sformatf("x_valid_%0d", i), out_valid_r, 1'b0);
    end

    // Idle after a valid 01 holds 0
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    after_edge();
    check("clr_pinit", pinit_r, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    check("clr_hold_pinit", pinit_r, 1'b0);
    check("clr_hold_valid", out_valid_r, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
